// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl
// Run controller for an N-bit Johnson phase counter. A start request
// accepted in IDLE launches a run of a programmed number of full
// 2N-step revolutions in either direction. The run supports hold and
// abort, and completion is flagged with a one-cycle done pulse.
//
// Optional feature macro: JSC_PRELOAD_EN adds a phase preload port set
// (load_i, load_val_i, load_err_o). The preload is accepted in IDLE only.
//
// Ports
//   clk_i          rising-edge clock
//   reset_n_i      asynchronous active-low reset
//   start_i        run request, sampled in IDLE only
//   cycles_i       revolutions to run, latched on an accepted start
//   dir_i          0: shift right, inject ~q[0] at the MSB;
//                  1: shift left, inject ~q[N-1] at the LSB
//   hold_i         freezes stepping while high (RUN only)
//   abort_i        cancels a run; takes priority over hold and step
//   phase_o        Johnson counter value
//   busy_o         high while in RUN
//   done_o         one-cycle pulse on normal completion
//   cycles_left_o  revolutions remaining, including the current one
//   load_i         (JSC_PRELOAD_EN) preload request, IDLE only
//   load_val_i     (JSC_PRELOAD_EN) preload value
//   load_err_o     (JSC_PRELOAD_EN) one-cycle pulse on an illegal preload code
//
// state | meaning
// IDLE  | waiting for start (or load); phase holds its last value
// RUN   | stepping phase; counting revolutions down
// DONE  | one-cycle completion state that drives done_o

module johnson_seq_ctrl #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] cycles_i,
   input  logic             dir_i,
   input  logic             hold_i,
   input  logic             abort_i,
   output logic [N-1:0]     phase_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cycles_left_o
`ifdef JSC_PRELOAD_EN
   ,
   input  logic             load_i,
   input  logic [N-1:0]     load_val_i,
   output logic             load_err_o
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [N-1:0]     phase_q, phase_d;
   logic [N-1:0]     start_phase_q, start_phase_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] left_q, left_d;
   logic             busy_q, done_q;
   logic [N-1:0]     step_val;

`ifdef JSC_PRELOAD_EN
   logic load_err_q, load_err_d;

   // A legal Johnson code has at most one transition between adjacent bits.
   function automatic logic legal_code(input logic [N-1:0] v);
      int t;
      t = 0;
      for (int i = 0; i < N - 1; i++) begin
         if (v[i] != v[i+1]) t++;
      end
      return (t <= 1);
   endfunction
`endif

   always_comb begin
      if (dir_q) step_val = {phase_q[N-2:0], ~phase_q[N-1]};
      else       step_val = {~phase_q[0], phase_q[N-1:1]};
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      start_phase_d = start_phase_q;
      dir_d         = dir_q;
      left_d        = left_q;
`ifdef JSC_PRELOAD_EN
      load_err_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef JSC_PRELOAD_EN
            if (load_i) begin
               if (legal_code(load_val_i)) begin
                  phase_d = load_val_i;
               end else begin
                  phase_d    = '0;
                  load_err_d = 1'b1;
               end
            end else
`endif
            if (start_i) begin
               left_d = cycles_i;
               if (cycles_i != '0) begin
                  state_d       = ST_RUN;
                  dir_d         = dir_i;
                  start_phase_d = phase_q;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               phase_d = '0;
               left_d  = '0;
               state_d = ST_IDLE;
            end else if (!hold_i) begin
               phase_d = step_val;
               // Returning to the phase captured at start closes a revolution.
               if (step_val == start_phase_q && left_q != '0) begin
                  left_d = left_q - CNT_W'(1);
                  if (left_q == CNT_W'(1)) state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= ST_IDLE;
         phase_q       <= '0;
         start_phase_q <= '0;
         dir_q         <= 1'b0;
         left_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
`ifdef JSC_PRELOAD_EN
         load_err_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         start_phase_q <= start_phase_d;
         dir_q         <= dir_d;
         left_q        <= left_d;
         // Status flags are registered copies of the next state so they
         // change on the same edge as the state itself.
         busy_q        <= (state_d == ST_RUN);
         done_q        <= (state_d == ST_DONE);
`ifdef JSC_PRELOAD_EN
         load_err_q    <= load_err_d;
`endif
      end
   end

   assign phase_o       = phase_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign cycles_left_o = left_q;
`ifdef JSC_PRELOAD_EN
   assign load_err_o    = load_err_q;
`endif

endmodule
